// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable countdown timer used for game rounds and mole-visible windows.
//   It counts down once per rising edge of the divided square wave tick_in.
//   When the count reaches zero it raises a held done level and a one-cycle
//   expired pulse.
//
// Ports
//   clk       in   1      system clock; all logic runs on posedge clk
//   reset     in   1      synchronous, active-high reset
//   tick_in   in   1      divided square wave, synchronous to clk (level)
//   load_val  in   WIDTH  start value, sampled only while start=1
//   start     in   1      load load_val and begin counting (from any state)
//   pause     in   1      level; while high in RUN/PAUSE, ticks are discarded
//   count     out  WIDTH  remaining ticks
//   running   out  1      high in RUN only
//   done      out  1      high in DONE (held until start or reset)
//   expired   out  1      one-cycle pulse on every entry into DONE
// -----------------------------------------------------------------------------
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             tick_q_r;
  logic             tick_rise_s;
  logic             expire_s;
  logic             running_r;
  logic             done_r;
  logic             expired_r;

  // A held-high tick_in counts only once: act on the 0->1 transition.
  assign tick_rise_s = tick_in & ~tick_q_r;

  // Next-state and next-count decode; start outranks pause, pause outranks ticks.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    expire_s     = 1'b0;
    if (start) begin
      count_next_s = load_val;
      if (load_val == CNT_ZERO) begin
        state_next_s = DONE;
        expire_s     = 1'b1;
      end else begin
        state_next_s = RUN;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        RUN: begin
          if (pause) begin
            // A tick rising together with pause is dropped, not deferred.
            state_next_s = PAUSE;
          end else if (tick_rise_s) begin
            if (count_r > CNT_ONE) begin
              count_next_s = count_r - CNT_ONE;
            end else begin
              count_next_s = CNT_ZERO;
              state_next_s = DONE;
              expire_s     = 1'b1;
            end
          end else begin
            state_next_s = RUN;
          end
        end
        PAUSE: begin
          // Ticks seen while paused (including on the release cycle) are lost.
          if (pause) begin
            state_next_s = PAUSE;
          end else begin
            state_next_s = RUN;
          end
        end
        DONE: begin
          count_next_s = CNT_ZERO;
        end
        default: begin
          state_next_s = IDLE;
          count_next_s = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count, tick history and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= CNT_ZERO;
      tick_q_r  <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      count_r   <= count_next_s;
      tick_q_r  <= tick_in;
      running_r <= (state_next_s == RUN);
      done_r    <= (state_next_s == DONE);
      expired_r <= expire_s;
    end
  end

  assign count   = count_r;
  assign running = running_r;
  assign done    = done_r;
  assign expired = expired_r;

endmodule

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//   Self-checking bench for down_timer. Each record holds one cycle of inputs
//   and the outputs expected right after the clock edge that samples them.
//   Expected values are pushed to a scoreboard queue when the inputs are
//   driven and popped/compared once the edge has happened.
// -----------------------------------------------------------------------------
module tb_down_timer;

  typedef struct packed {
    logic       rst;
    logic       st;
    logic       pa;
    logic       tk;
    logic [7:0] ld;
    logic [7:0] cnt;
    logic       run;
    logic       dn;
    logic       ex;
  } vec_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic       run;
    logic       dn;
    logic       ex;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       expired;

  int n_checks;
  int n_pass;
  int step_no;

  vec_t vecs[$];
  exp_t sb[$];

  down_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .count    (count),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic p,
                              input logic t, input logic [7:0] l,
                              input logic [7:0] c, input logic ru,
                              input logic d, input logic e);
    vec_t v;
    v.rst = r; v.st = s; v.pa = p; v.tk = t; v.ld = l;
    v.cnt = c; v.run = ru; v.dn = d; v.ex = e;
    return v;
  endfunction

  // Drive one cycle of inputs, then compare outputs just after the edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset    = v.rst;
    start    = v.st;
    pause    = v.pa;
    tick_in  = v.tk;
    load_val = v.ld;
    e.cnt = v.cnt; e.run = v.run; e.dn = v.dn; e.ex = v.ex;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    got.cnt = count; got.run = running; got.dn = done; got.ex = expired;
    n_checks++;
    if (got === e) begin
      n_pass++;
    end else begin
      $display("FAIL step%0d cnt/run/done/exp got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
               step_no, got.cnt, got.run, got.dn, got.ex, e.cnt, e.run, e.dn, e.ex);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    step_no  = 0;
    reset    = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    tick_in  = 1'b0;
    load_val = 8'd0;

    // ---- table: reset, countdown from 3 with tick period 4 clk ----
    //                 rst   st    pa    tk    ld     cnt   run   dn    ex
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0)); // IDLE ignores
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0)); // DONE ignores ticks
    // ---- start with load 0: immediate DONE, pulse again on restart ----
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    // ---- restart mid-count beats a same-cycle tick, then reset mid-count ----
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd9, 8'd9, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd9, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd8, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 8'd0, 1'b0, 1'b0, 1'b0)); // reset wins
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // ---- held-high tick counts once ----
    run_vec(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      run_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0));
    end
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0));

    // ---- pause drops same-cycle and in-pause ticks; next rise after release counts ----
    run_vec(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 8'd4, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0));
      run_vec(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0));
    end
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0));
    // a rise on the release cycle itself is lost
    run_vec(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0));

    // ---- maximum load value ----
    run_vec(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd254, 1'b1, 1'b0, 1'b0));

    // ---- countdown from 1 expires on the first rise ----
    run_vec(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 1'b1, 1'b0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    run_vec(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
